spi_register_bank: RTL and testbench

Parametrised bank of SPI-addressed registers that sits on the shared `spi_peripheral` opcode/operand bus in the SPI clock domain, alongside the camera and graphics blocks. It generalises the single fixed read-only ID register to `REGISTER_COUNT` consecutive addresses of `REGISTER_BYTES` bytes each. Each register is either read/write (stored, driven to fabric) or read-only (sampled from fabric). Multi-byte reads are snapshotted and multi-byte writes commit atomically at transaction end.

---
 rtl/spi_register_bank.sv | 152 +++++++++++++++
 tb/tb_spi_register_bank.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_register_bank.sv
// Bank of SPI-addressed registers on the shared opcode/operand bus.
// Reads come from a snapshot taken at transaction start. Writes commit atomically when the transaction ends.
//
// state  | meaning
// IDLE   | waiting for a rising edge of opcode_valid_in
// ACTIVE | transaction addressed to this bank; responding and collecting writes
// IGNORE | transaction for another block; wait for opcode_valid_in to fall
module spi_register_bank #(
  parameter int unsigned BASE_ADDRESS = 'h00,
  parameter int unsigned REGISTER_COUNT = 4,
  parameter int unsigned REGISTER_BYTES = 1,
  parameter logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] RESET_VALUES = '0,
  parameter logic [REGISTER_COUNT-1:0] WRITABLE_MASK = '0
) (
  input  logic                                   clock_in,
  input  logic                                   reset_n_in,
  input  logic [7:0]                             opcode_in,
  input  logic                                   opcode_valid_in,
  input  logic [7:0]                             operand_in,
  input  logic                                   operand_valid_in,
  input  logic [31:0]                            operand_count_in,
  input  logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] hw_value_in,
  output logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] register_value_out,
  output logic [REGISTER_COUNT-1:0]              write_strobe_out,
  output logic [7:0]                             response_out,
  output logic                                   response_valid_out
);
  localparam int unsigned W = REGISTER_BYTES * 8;
  localparam int unsigned SEL_W = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, IGNORE} state_t;

  state_t state, state_next;
  logic opcode_valid_d;
  logic rise, in_range, enter_active, leave_active, write_byte, commit;
  logic [8:0] offset;
  logic [SEL_W-1:0] sel;
  logic sel_writable, entry_writable;
  logic got_operand;
  logic [31:0] read_k;
  logic [W-1:0] regs [REGISTER_COUNT];
  logic [W-1:0] entry_value, snapshot, shadow;
  logic [REGISTER_BYTES-1:0] flags;

  function automatic logic [7:0] byte_of(input logic [W-1:0] value, input logic [31:0] k);
    logic [7:0] result;
    result = 8'h00;
    for (int b = 0; b < int'(REGISTER_BYTES); b++)
      if (k == 32'(b)) result = value[(int'(REGISTER_BYTES) - 1 - b) * 8 +: 8];
    return result;
  endfunction

  // Opcodes below the base wrap to >= 257 in 9 bits, so one compare covers both ends.
  assign offset = {1'b0, opcode_in} - 9'(BASE_ADDRESS);
  assign in_range = offset < 9'(REGISTER_COUNT);
  assign rise = opcode_valid_in && !opcode_valid_d;
  assign enter_active = (state == IDLE) && rise && in_range;
  assign leave_active = (state == ACTIVE) && !opcode_valid_in;
  assign write_byte = (state == ACTIVE) && opcode_valid_in && operand_valid_in && sel_writable
                      && (operand_count_in < 32'(REGISTER_BYTES));
  assign commit = leave_active && sel_writable && (&flags);
  assign read_k = (operand_valid_in || got_operand) ? operand_count_in : 32'd0;
  assign response_valid_out = (state == ACTIVE);

  always_comb begin
    entry_value = '0;
    entry_writable = 1'b0;
    for (int i = 0; i < int'(REGISTER_COUNT); i++) begin
      if (offset == 9'(i)) begin
        entry_value = WRITABLE_MASK[i] ? regs[i] : hw_value_in[i*W +: W];
        entry_writable = WRITABLE_MASK[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:           if (rise) state_next = in_range ? ACTIVE : IGNORE;
      ACTIVE, IGNORE: if (!opcode_valid_in) state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else state <= state_next;
  end

  // Reset to 1 so a transaction already in flight when reset releases is not picked up mid-way.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) opcode_valid_d <= 1'b1;
    else opcode_valid_d <= opcode_valid_in;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sel <= '0;
      sel_writable <= 1'b0;
      snapshot <= '0;
      shadow <= '0;
      flags <= '0;
      got_operand <= 1'b0;
    end else if (enter_active) begin
      sel <= offset[SEL_W-1:0];
      sel_writable <= entry_writable;
      snapshot <= entry_value;
      shadow <= '0;
      flags <= '0;
      got_operand <= 1'b0;
    end else begin
      if ((state == ACTIVE) && opcode_valid_in && operand_valid_in) got_operand <= 1'b1;
      for (int b = 0; b < int'(REGISTER_BYTES); b++) begin
        if (write_byte && (operand_count_in == 32'(b))) begin
          shadow[(int'(REGISTER_BYTES) - 1 - b) * 8 +: 8] <= operand_in;
          flags[b] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < int'(REGISTER_COUNT); i++) regs[i] <= RESET_VALUES[i*W +: W];
    end else if (commit) begin
      for (int i = 0; i < int'(REGISTER_COUNT); i++)
        if (sel == SEL_W'(i)) regs[i] <= shadow;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      write_strobe_out <= '0;
    end else begin
      for (int i = 0; i < int'(REGISTER_COUNT); i++)
        write_strobe_out[i] <= commit && (sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) response_out <= 8'h00;
    else if (enter_active) response_out <= byte_of(entry_value, 32'd0);
    else if ((state == ACTIVE) && opcode_valid_in) response_out <= byte_of(snapshot, read_k);
    else response_out <= 8'h00;
  end

  always_comb begin
    register_value_out = '0;
    for (int i = 0; i < int'(REGISTER_COUNT); i++)
      if (WRITABLE_MASK[i]) register_value_out[i*W +: W] = regs[i];
  end
endmodule

// File: tb/tb_spi_register_bank.sv
// Scoreboard bench for spi_register_bank: the stimulus queues expected responses, strobes and register contents.
// A monitor pops those queues and compares them with the DUT outputs.
module tb_spi_register_bank;
  localparam int BASE = 'h20;
  localparam int COUNT = 4;
  localparam int BYTES = 2;
  localparam logic [63:0] RESETS = 64'h0102_7777_C0DE_BEEF;
  localparam logic [3:0] WRITABLE = 4'b1011;

  logic clock_in = 1'b0;
  logic reset_n_in = 1'b1;
  logic [7:0] opcode_in = '0;
  logic opcode_valid_in = 1'b0;
  logic [7:0] operand_in = '0;
  logic operand_valid_in = 1'b0;
  logic [31:0] operand_count_in = '0;
  logic [63:0] hw_value_in = '0;
  logic [63:0] register_value_out;
  logic [3:0] write_strobe_out;
  logic [7:0] response_out;
  logic response_valid_out;

  spi_register_bank #(
    .BASE_ADDRESS(BASE), .REGISTER_COUNT(COUNT), .REGISTER_BYTES(BYTES),
    .RESET_VALUES(RESETS), .WRITABLE_MASK(WRITABLE)
  ) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in),
    .opcode_in(opcode_in), .opcode_valid_in(opcode_valid_in),
    .operand_in(operand_in), .operand_valid_in(operand_valid_in),
    .operand_count_in(operand_count_in), .hw_value_in(hw_value_in),
    .register_value_out(register_value_out), .write_strobe_out(write_strobe_out),
    .response_out(response_out), .response_valid_out(response_valid_out)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int failures = 0;
  logic [7:0] resp_q[$];
  logic [3:0] strobe_q[$];
  logic [15:0] model [COUNT];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_view();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < COUNT; i++) if (WRITABLE[i]) v[i*16 +: 16] = model[i];
    return v;
  endfunction

  function automatic logic [7:0] model_byte(input logic [15:0] v, input int k);
    if (k >= BYTES) return 8'h00;
    return 8'(v >> (8 * (BYTES - 1 - k)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < COUNT; i++) model[i] = RESETS[i*16 +: 16];
  endtask

  task automatic step(input logic ov, input logic [7:0] opc, input logic opv, input logic [7:0] op,
                      input int cnt, input logic [63:0] hw);
    @(negedge clock_in);
    opcode_valid_in = ov;
    opcode_in = opc;
    operand_valid_in = opv;
    operand_in = op;
    operand_count_in = 32'(cnt);
    hw_value_in = hw;
    @(posedge clock_in);
  endtask

  // One SPI transaction: select, one idle byte slot, n operand bytes, release.
  task automatic xact(input logic [7:0] opc, input int n, input logic [23:0] data,
                      input logic [63:0] hw_entry, input logic [63:0] hw_mid);
    int idx;
    bit hit;
    logic [15:0] snap;
    idx = int'(opc) - BASE;
    hit = (idx >= 0) && (idx < COUNT);
    snap = '0;
    if (hit) snap = WRITABLE[idx] ? model[idx] : hw_entry[idx*16 +: 16];
    step(1'b1, opc, 1'b0, 8'h00, 0, hw_entry);
    if (hit) resp_q.push_back(model_byte(snap, 0));
    step(1'b1, opc, 1'b0, 8'h00, 0, hw_mid);
    if (hit) resp_q.push_back(model_byte(snap, 0));
    for (int j = 0; j < n; j++) begin
      step(1'b1, opc, 1'b1, data[23 - 8*j -: 8], j, hw_mid);
      if (hit) resp_q.push_back(model_byte(snap, j));
      step(1'b1, opc, 1'b0, 8'($urandom), j, hw_mid);
      if (hit) resp_q.push_back(model_byte(snap, j));
    end
    step(1'b0, opc, 1'($urandom), 8'($urandom), (n > 0) ? n - 1 : 0, hw_mid);
    if (hit && WRITABLE[idx] && (n >= BYTES)) begin
      model[idx] = data[23:8];
      strobe_q.push_back(4'(1 << idx));
    end
  endtask

  initial begin
    forever begin
      @(negedge clock_in);
      if (response_valid_out !== 1'b0) begin
        if (resp_q.size() == 0) check("spurious_response_valid", 64'(response_valid_out), 64'd0);
        else check("response_byte", 64'(response_out), 64'(resp_q.pop_front()));
      end
      if (write_strobe_out !== 4'b0000) begin
        if (strobe_q.size() == 0) check("spurious_write_strobe", 64'(write_strobe_out), 64'd0);
        else check("write_strobe", 64'(write_strobe_out), 64'(strobe_q.pop_front()));
      end
      check("register_value", register_value_out, model_view());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached expected bench finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [63:0] hw;
    model_reset();
    #1 reset_n_in = 1'b0;
    #1;
    check("reset_response_valid", 64'(response_valid_out), 64'd0);
    check("reset_response", 64'(response_out), 64'd0);
    check("reset_strobe", 64'(write_strobe_out), 64'd0);
    check("reset_registers", register_value_out, 64'h0102_0000_C0DE_BEEF);
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    #1 reset_n_in = 1'b1;

    xact(8'h20, 3, 24'hBEEF00, 64'h0, 64'h0);
    xact(8'h21, 2, 24'h123400, 64'h0, 64'h0);
    xact(8'h21, 0, 24'h000000, 64'h0, 64'h0);
    xact(8'h21, 2, 24'h123400, 64'h0, 64'h0);
    xact(8'h21, 1, 24'hAA0000, 64'h0, 64'h0);
    xact(8'h22, 2, 24'hFFFF00, 64'h0000_5A5A_0000_0000, 64'h0);
    xact(8'hDB, 2, 24'h112233, 64'h0, 64'h0);

    hw = 64'h0;
    step(1'b1, 8'h21, 1'b0, 8'h00, 0, hw);
    resp_q.push_back(model_byte(model[1], 0));
    step(1'b1, 8'h21, 1'b1, 8'h99, 0, hw);
    resp_q.push_back(model_byte(model[1], 0));
    @(negedge clock_in);
    #1 reset_n_in = 1'b0;
    model_reset();
    #1;
    check("midreset_response_valid", 64'(response_valid_out), 64'd0);
    check("midreset_registers", register_value_out, 64'h0102_0000_C0DE_BEEF);
    check("midreset_strobe", 64'(write_strobe_out), 64'd0);
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    #1 reset_n_in = 1'b1;
    step(1'b1, 8'h21, 1'b1, 8'h77, 1, hw);
    step(1'b1, 8'h21, 1'b0, 8'h00, 1, hw);
    step(1'b0, 8'h21, 1'b0, 8'h00, 1, hw);

    for (int t = 0; t < 60; t++) begin
      logic [7:0] opc;
      logic [63:0] h0, h1;
      opc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(BASE - 1 + $urandom_range(0, 5));
      h0 = {$urandom, $urandom};
      h1 = {$urandom, $urandom};
      xact(opc, $urandom_range(0, 3), 24'($urandom), h0, h1);
      if ($urandom_range(0, 1) == 1) step(1'b0, 8'($urandom), 1'($urandom), 8'($urandom), 0, h1);
    end

    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    #1;
    check("response_queue_drained", 64'(resp_q.size()), 64'd0);
    check("strobe_queue_drained", 64'(strobe_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
